logic_unit_pipe: RTL and testbench
==================================

// Module: logic_unit_pipe
// PURPOSE
//   Parametrised, pipelined successor of the 16-bit logic unit. Supports 8 bitwise ops,
//   valid/ready handshakes on both sides with full back-pressure, and registered result flags.
//   Sits beside the arithmetic/shift units in the ALU datapath. Fed by the operand/decode stage;
//   drains into the ALU result mux.
// PARAMETERS
//   IN_WIDTH     16  operand and result width in bits (>=2)
//   PIPE_STAGES  2   register stages from input capture to output (1..4)
//   CNT_WIDTH    16  width of the completed-operation counter
// PORTS
//   CLK        in   1          clock; all state updates on the rising edge
//   RST        in   1          asynchronous active-low reset
//   A          in   IN_WIDTH   operand A
//   B          in   IN_WIDTH   operand B
//   ALU_FUN    in   3          op select, sampled with A/B
//   IN_VALID   in   1          A/B/ALU_FUN valid this cycle
//   IN_READY   out  1          unit accepts input this cycle
//   Logic_OUT  out  IN_WIDTH   result
//   OUT_VALID  out  1          Logic_OUT and flags valid
//   OUT_READY  in   1          downstream accepts result
//   Zero_Flag  out  1          Logic_OUT == 0
//   Ones_Flag  out  1          Logic_OUT == all ones
//   Par_Flag   out  1          XOR-reduce of Logic_OUT (odd parity)
//   Op_Cnt     out  CNT_WIDTH  count of output transfers, wraps modulo 2^CNT_WIDTH
// BEHAVIOUR
//   Reset (RST=0, async): all stage valid bits, Logic_OUT, flags and Op_Cnt clear to 0,
//     so OUT_VALID=0. IN_READY is combinational and therefore reads 1 during reset.
//   Ops (ALU_FUN):
//     0 A&B    1 A|B    2 ~(A&B)    3 ~(A|B)
//     4 A^B    5 ~(A^B) 6 ~A        7 B
//     All codes are defined; there is no illegal-op case.
//   Operands are treated as unsigned bit vectors; the result is exactly IN_WIDTH bits.
//   Pipeline:
//     stage 1 registers op(A,B) plus its valid bit; stages 2..PIPE_STAGES are delay registers.
//     Flags are computed from the stage-final result and registered with it.
//   Advance rule (global stall):
//     adv = ~OUT_VALID | OUT_READY; IN_READY = adv.
//     When adv=1, every stage loads from its predecessor. Stage 1 loads IN_VALID and the op result.
//     When adv=0, all stages hold. Bubbles are not compressed during a stall.
//   Transfers:
//     Input handshake = IN_VALID & IN_READY.
//     Output handshake = OUT_VALID & OUT_READY.
//     A non-accepted input (IN_VALID=0 or adv=0) is never captured. Stage 1 valid gets 0 on adv
//     with IN_VALID=0.
//   Latency: with OUT_READY held at 1, a result accepted at edge N appears with OUT_VALID=1
//     after edge N+PIPE_STAGES-1. Throughput is 1 op/cycle.
//   Holding: while OUT_VALID=1 & OUT_READY=0, Logic_OUT and all flags stay stable.
//   Empty output slot: when OUT_VALID=0, Logic_OUT and the flags hold their last values;
//     downstream ignores them.
//   Op_Cnt increments by 1 on each output handshake. All-ones wraps to 0.
//   Simultaneous input and output handshake in one cycle is legal; nothing is dropped
//     or duplicated.
//   Mid-operation reset: in-flight results are discarded and Op_Cnt clears.
//     The first valid after reset release follows the latency rule.
// TESTING (IN_WIDTH=16, PIPE_STAGES=2, OUT_READY=1 unless stated)
//   1. Reset: RST=0 mid-stream -> next cycle OUT_VALID=0, Logic_OUT=0, Op_Cnt=0, flags=0.
//   2. All ops: A=16'hF0F0, B=16'hFF00, ALU_FUN=0..7 back-to-back. Required Logic_OUT in order:
//        F000, FFF0, 0FFF, 000F, 0FF0, F00F, 0F0F, FF00
//      Results arrive at 1/cycle, 2 cycles after each input; Op_Cnt ends at 8.
//   3. Flags:
//        op 0, A=16'h00FF, B=16'hFF00   -> Zero_Flag=1, Par_Flag=0
//        op 5, A=B=16'h1234             -> Ones_Flag=1
//        op 7, B=16'h0001               -> Par_Flag=1
//   4. Back-pressure: issue 3 ops with OUT_READY=0 -> IN_READY drops once OUT_VALID=1.
//      Output holds the first result unchanged. Raise OUT_READY -> all 3 results drain
//      in order, with no loss or duplicates.
//   5. Random IN_VALID/OUT_READY, 10k cycles, checked against a reference queue.
//      Data is in-order and lossless; Op_Cnt equals the number of output handshakes.
//   6. Wrap: CNT_WIDTH=4, 17 transfers -> Op_Cnt=1.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit with valid/ready handshakes on both sides.
// Stage 1 captures op(A,B). Later stages are delay registers.
// Result flags are registered together with the final stage.
// A single global advance signal stalls every stage whenever the output
// holds a result that downstream has not taken.
module logic_unit_pipe #(
  parameter int IN_WIDTH    = 16,
  parameter int PIPE_STAGES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [IN_WIDTH-1:0]  A,
  input  logic [IN_WIDTH-1:0]  B,
  input  logic [2:0]           ALU_FUN,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  output logic [IN_WIDTH-1:0]  Logic_OUT,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic                 Zero_Flag,
  output logic                 Ones_Flag,
  output logic                 Par_Flag,
  output logic [CNT_WIDTH-1:0] Op_Cnt
);

  localparam int LAST = PIPE_STAGES - 1;

  // Bitwise operation selected by fun; every code is defined.
  function automatic logic [IN_WIDTH-1:0] f_logic_op(
    input logic [IN_WIDTH-1:0] a,
    input logic [IN_WIDTH-1:0] b,
    input logic [2:0]          fun
  );
    logic [IN_WIDTH-1:0] res;
    case (fun)
      3'd0:    res = a & b;
      3'd1:    res = a | b;
      3'd2:    res = ~(a & b);
      3'd3:    res = ~(a | b);
      3'd4:    res = a ^ b;
      3'd5:    res = ~(a ^ b);
      3'd6:    res = ~a;
      3'd7:    res = b;
      default: res = b;
    endcase
    return res;
  endfunction

  // Odd parity: 1 when the vector holds an odd number of ones.
  function automatic logic f_odd_parity(input logic [IN_WIDTH-1:0] v);
    return ^v;
  endfunction

  logic [IN_WIDTH-1:0]    r_data [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] r_valid;
  logic                   r_zero;
  logic                   r_ones;
  logic                   r_par;
  logic [CNT_WIDTH-1:0]   r_cnt;

  logic                   w_adv;
  logic [IN_WIDTH-1:0]    w_op_res;
  logic [IN_WIDTH-1:0]    w_final_d;
  logic                   w_final_v;
  logic                   w_out_hs;

  assign w_adv    = ~r_valid[LAST] | OUT_READY;
  assign w_op_res = f_logic_op(A, B, ALU_FUN);
  assign w_out_hs = r_valid[LAST] & OUT_READY;

  // The final stage's predecessor is either the op itself or the previous stage.
  generate
    if (PIPE_STAGES == 1) begin : g_single
      assign w_final_d = w_op_res;
      assign w_final_v = IN_VALID;
    end else begin : g_multi
      assign w_final_d = r_data[LAST-1];
      assign w_final_v = r_valid[LAST-1];
    end
  endgenerate

  // Valid bits shift together on advance; a missing input injects a bubble.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_valid <= '0;
    end else if (w_adv) begin
      r_valid[0] <= IN_VALID;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        r_valid[i] <= r_valid[i-1];
      end
    end
  end

  // Data registers load only real results so an empty slot keeps its last value.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
        r_data[i] <= '0;
      end
    end else if (w_adv) begin
      if (IN_VALID) begin
        r_data[0] <= w_op_res;
      end
      for (int i = 1; i < PIPE_STAGES; i++) begin
        if (r_valid[i-1]) begin
          r_data[i] <= r_data[i-1];
        end
      end
    end
  end

  // Flags are derived from the value entering the final stage and stored alongside it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_zero <= 1'b0;
      r_ones <= 1'b0;
      r_par  <= 1'b0;
    end else if (w_adv && w_final_v) begin
      r_zero <= (w_final_d == {IN_WIDTH{1'b0}});
      r_ones <= &w_final_d;
      r_par  <= f_odd_parity(w_final_d);
    end
  end

  // Completed-operation counter; wraps naturally at all ones.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cnt <= '0;
    end else if (w_out_hs) begin
      r_cnt <= r_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign IN_READY  = w_adv;
  assign Logic_OUT = r_data[LAST];
  assign OUT_VALID = r_valid[LAST];
  assign Zero_Flag = r_zero;
  assign Ones_Flag = r_ones;
  assign Par_Flag  = r_par;
  assign Op_Cnt    = r_cnt;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed and randomized checks for logic_unit_pipe (16-bit, 2 stages).
// A second instance with a 4-bit counter shares all inputs to check counter wrap.
module tb_logic_unit_pipe;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] A = 16'h0000;
  logic [15:0] B = 16'h0000;
  logic [2:0]  ALU_FUN = 3'd0;
  logic        IN_VALID = 1'b0;
  logic        OUT_READY = 1'b1;
  logic        IN_READY, OUT_VALID, Zero_Flag, Ones_Flag, Par_Flag;
  logic [15:0] Logic_OUT;
  logic [15:0] Op_Cnt;
  logic        IN_READY_w, OUT_VALID_w, Zero_Flag_w, Ones_Flag_w, Par_Flag_w;
  logic [15:0] Logic_OUT_w;
  logic [3:0]  Op_Cnt_w;

  logic_unit_pipe #(.IN_WIDTH(16), .PIPE_STAGES(2), .CNT_WIDTH(16)) u_dut (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .ALU_FUN(ALU_FUN), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .Logic_OUT(Logic_OUT), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .Zero_Flag(Zero_Flag), .Ones_Flag(Ones_Flag),
    .Par_Flag(Par_Flag), .Op_Cnt(Op_Cnt)
  );

  logic_unit_pipe #(.IN_WIDTH(16), .PIPE_STAGES(2), .CNT_WIDTH(4)) u_dut_wrap (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .ALU_FUN(ALU_FUN), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY_w), .Logic_OUT(Logic_OUT_w), .OUT_VALID(OUT_VALID_w),
    .OUT_READY(OUT_READY), .Zero_Flag(Zero_Flag_w), .Ones_Flag(Ones_Flag_w),
    .Par_Flag(Par_Flag_w), .Op_Cnt(Op_Cnt_w)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  fun;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        z;
    logic        o;
    logic        p;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  int n_vec = 0;
  int n_err = 0;
  int exp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int idx);
    A        = vecs[idx].a;
    B        = vecs[idx].b;
    ALU_FUN  = vecs[idx].fun;
    IN_VALID = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b0;
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    @(negedge CLK);
    RST = 1'b1;
    exp_cnt = 0;
  endtask

  // Stream vecs[lo..hi] back to back with OUT_READY=1 and check each result
  // one edge after capture, plus the running counter.
  task automatic stream(input int lo, input int hi);
    int n;
    int base;
    n = hi - lo + 1;
    base = exp_cnt;
    for (int i = 0; i < n + 2; i++) begin
      @(negedge CLK);
      if (i >= 2) begin
        chk("stream_valid", OUT_VALID, 1);
        chk("stream_data", Logic_OUT, vecs[lo+i-2].res);
        chk("stream_zero", Zero_Flag, vecs[lo+i-2].z);
        chk("stream_ones", Ones_Flag, vecs[lo+i-2].o);
        chk("stream_par", Par_Flag, vecs[lo+i-2].p);
        chk("stream_cnt", Op_Cnt, base + i - 2);
      end
      if (i < n) drive(lo + i);
      else IN_VALID = 1'b0;
    end
    @(negedge CLK);
    exp_cnt = base + n;
    chk("stream_drained", OUT_VALID, 0);
    chk("stream_final_cnt", Op_Cnt, exp_cnt);
    chk("stream_final_cnt_w", Op_Cnt_w, exp_cnt % 16);
  endtask

  function automatic logic [15:0] ref_op(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b);
    case (f)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return ~(a & b);
      3'd3: return ~(a | b);
      3'd4: return a ^ b;
      3'd5: return ~(a ^ b);
      3'd6: return ~a;
      default: return b;
    endcase
  endfunction

  logic [15:0] q [$];
  logic [15:0] exp_r;
  int          hs;
  bit          pend;

  initial begin
    vecs[0]  = '{3'd0, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{3'd1, 16'hF0F0, 16'hFF00, 16'hFFF0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{3'd2, 16'hF0F0, 16'hFF00, 16'h0FFF, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{3'd3, 16'hF0F0, 16'hFF00, 16'h000F, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{3'd4, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{3'd5, 16'hF0F0, 16'hFF00, 16'hF00F, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{3'd6, 16'hF0F0, 16'hFF00, 16'h0F0F, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{3'd7, 16'hF0F0, 16'hFF00, 16'hFF00, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{3'd0, 16'h00FF, 16'hFF00, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{3'd5, 16'h1234, 16'h1234, 16'hFFFF, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{3'd7, 16'hABCD, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{3'd3, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{3'd2, 16'hFFFF, 16'h7FFF, 16'h8000, 1'b0, 1'b0, 1'b1};

    // Reset state while RST is asserted.
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_in_ready", IN_READY, 1);
    chk("rst_data", Logic_OUT, 0);
    chk("rst_cnt", Op_Cnt, 0);
    RST = 1'b1;

    // Mid-stream reset discards in-flight work and clears the counter.
    @(negedge CLK); drive(0);
    @(negedge CLK); drive(1);
    @(negedge CLK); drive(2);
    @(negedge CLK); drive(3);
    @(negedge CLK); IN_VALID = 1'b0;
    chk("pre_rst_valid", OUT_VALID, 1);
    chk("pre_rst_data", Logic_OUT, vecs[2].res);
    chk("pre_rst_cnt", Op_Cnt, 2);
    RST = 1'b0;
    @(negedge CLK);
    chk("mid_rst_valid", OUT_VALID, 0);
    chk("mid_rst_data", Logic_OUT, 0);
    chk("mid_rst_cnt", Op_Cnt, 0);
    chk("mid_rst_flags", {Zero_Flag, Ones_Flag, Par_Flag}, 0);
    chk("mid_rst_in_ready", IN_READY, 1);
    RST = 1'b1;
    @(negedge CLK); drive(10);
    @(negedge CLK); IN_VALID = 1'b0;
    chk("post_rst_lat0", OUT_VALID, 0);
    @(negedge CLK);
    chk("post_rst_valid", OUT_VALID, 1);
    chk("post_rst_data", Logic_OUT, 16'h0001);
    chk("post_rst_par", Par_Flag, 1);
    @(negedge CLK);
    chk("post_rst_cnt", Op_Cnt, 1);
    chk("post_rst_empty", OUT_VALID, 0);
    chk("empty_slot_hold", Logic_OUT, 16'h0001);

    // All ops back to back, then flag vectors.
    do_reset();
    stream(0, 7);
    stream(8, NVEC - 1);

    // Back-pressure: three ops with OUT_READY low.
    do_reset();
    OUT_READY = 1'b0;
    @(negedge CLK); drive(0); #1 chk("bp_rdy0", IN_READY, 1);
    @(negedge CLK); drive(1); #1 chk("bp_rdy1", IN_READY, 1);
    @(negedge CLK);
    chk("bp_first_valid", OUT_VALID, 1);
    drive(4);
    #1 chk("bp_rdy_drop", IN_READY, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("bp_hold_valid", OUT_VALID, 1);
      chk("bp_hold_data", Logic_OUT, 16'hF000);
      chk("bp_hold_flags", {Zero_Flag, Ones_Flag, Par_Flag}, 0);
      chk("bp_hold_cnt", Op_Cnt, 0);
      chk("bp_hold_rdy", IN_READY, 0);
    end
    @(negedge CLK);
    OUT_READY = 1'b1;
    #1 chk("bp_release_rdy", IN_READY, 1);
    @(negedge CLK);
    IN_VALID = 1'b0;
    chk("bp_drain1", Logic_OUT, 16'hFFF0);
    chk("bp_drain1_cnt", Op_Cnt, 1);
    @(negedge CLK);
    chk("bp_drain2", Logic_OUT, 16'h0FF0);
    chk("bp_drain2_valid", OUT_VALID, 1);
    chk("bp_drain2_cnt", Op_Cnt, 2);
    @(negedge CLK);
    chk("bp_done_valid", OUT_VALID, 0);
    chk("bp_done_cnt", Op_Cnt, 3);
    chk("bp_done_hold", Logic_OUT, 16'h0FF0);

    // Random valid/ready against a reference queue.
    do_reset();
    hs = 0;
    pend = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge CLK);
      if (!pend) begin
        if ($urandom_range(0, 3) != 0) begin
          A = 16'($urandom);
          B = 16'($urandom);
          ALU_FUN = 3'($urandom_range(0, 7));
          IN_VALID = 1'b1;
          pend = 1'b1;
        end else begin
          IN_VALID = 1'b0;
        end
      end
      OUT_READY = ($urandom_range(0, 3) != 0);
      #1;
      if (IN_VALID && IN_READY) begin
        q.push_back(ref_op(ALU_FUN, A, B));
        pend = 1'b0;
      end
      if (OUT_VALID && OUT_READY) begin
        hs++;
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rand_extra_output: got %0h expected no output", Logic_OUT);
        end else begin
          exp_r = q.pop_front();
          chk("rand_data", Logic_OUT, exp_r);
          chk("rand_zero", Zero_Flag, exp_r == 16'h0000);
          chk("rand_ones", Ones_Flag, exp_r == 16'hFFFF);
          chk("rand_par", Par_Flag, $countones(exp_r) % 2);
        end
      end
    end
    @(negedge CLK);
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    #1;
    if (OUT_VALID) begin
      hs++;
      if (q.size() != 0) begin
        exp_r = q.pop_front();
        chk("rand_drain_data", Logic_OUT, exp_r);
      end
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      #1;
      if (OUT_VALID) begin
        hs++;
        if (q.size() != 0) begin
          exp_r = q.pop_front();
          chk("rand_drain_data", Logic_OUT, exp_r);
        end
      end
    end
    @(negedge CLK);
    chk("rand_queue_empty", q.size(), 0);
    chk("rand_cnt", Op_Cnt, hs % 65536);
    chk("rand_cnt_w", Op_Cnt_w, hs % 16);

    // Counter wrap: 17 transfers on the 4-bit counter instance.
    do_reset();
    for (int k = 0; k < 17; k++) begin
      @(negedge CLK);
      drive(k % NVEC);
    end
    @(negedge CLK);
    IN_VALID = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    chk("wrap_cnt_w", Op_Cnt_w, 1);
    chk("wrap_cnt", Op_Cnt, 17);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
